// File: rtl/apu_voice_sequencer_if.sv
// ---------------------------------------------------------------------------
// apu_voice_sequencer_if
//   Sound-effect trigger port between game logic (collision detector, player
//   logic) and the voice sequencer. A request is accepted on a cycle where
//   trig_valid and trig_ready are both high.
//
//   Signals
//     trig_valid   master -> slave  trigger request
//     trig_ready   slave  -> master sequencer can take a request this cycle
//     trig_voice   master -> slave  target voice index
//     trig_period  master -> slave  tone half-period in line_tick units (0 = silent)
//     trig_len     master -> slave  sustain length in frames (0 = straight to decay)
// ---------------------------------------------------------------------------
interface apu_voice_sequencer_if #(
  parameter int NUM_VOICES = 3,
  parameter int PERIOD_W   = 10,
  parameter int LEN_W      = 6
);
  localparam int VOICE_W = $clog2(NUM_VOICES + 1);

  logic                trig_valid;
  logic                trig_ready;
  logic [VOICE_W-1:0]  trig_voice;
  logic [PERIOD_W-1:0] trig_period;
  logic [LEN_W-1:0]    trig_len;

  modport master (
    output trig_valid,
    output trig_voice,
    output trig_period,
    output trig_len,
    input  trig_ready
  );

  modport slave (
    input  trig_valid,
    input  trig_voice,
    input  trig_period,
    input  trig_len,
    output trig_ready
  );
endinterface

// File: rtl/apu_voice_sequencer.sv
// ---------------------------------------------------------------------------
// apu_voice_sequencer
//   NUM_VOICES square-wave voices, each with a triggered sustain/decay
//   envelope, summed into a saturating mix and emitted as 1-bit PWM audio.
//
//   Ports
//     clk, reset    system clock, synchronous active-high reset
//     line_tick     one-clk pulse per scanline (tone timebase)
//     frame_tick    one-clk pulse per frame (envelope timebase)
//     trig          trigger port (apu_voice_sequencer_if.slave)
//     voice_active  bit i = voice i not idle; MSB = noise voice
//     trig_err      sticky: a trigger named a voice that does not exist
//     audio_out     PWM audio bit
//
//   Build option
//     APU_NOISE_EN  when defined, voice index NUM_VOICES is a noise voice
//                   whose amplitude source is bit 0 of a 13-bit LFSR stepped
//                   on every tone-counter wrap. Undefined: that index is out
//                   of range and voice_active MSB stays 0.
// ---------------------------------------------------------------------------
module apu_voice_sequencer #(
  parameter int NUM_VOICES = 3,
  parameter int PERIOD_W   = 10,
  parameter int ENV_W      = 5,
  parameter int LEN_W      = 6,
  parameter int PWM_W      = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  line_tick,
  input  logic                  frame_tick,
  apu_voice_sequencer_if.slave  trig,
  output logic [NUM_VOICES:0]   voice_active,
  output logic                  trig_err,
  output logic                  audio_out
);

  localparam int VOICE_W = $clog2(NUM_VOICES + 1);
`ifdef APU_NOISE_EN
  localparam int NV = NUM_VOICES + 1;
`else
  localparam int NV = NUM_VOICES;
`endif
  // Wide enough for up to 8 full-scale envelopes and for the PWM range.
  localparam int SUM_W = (ENV_W + 3 > PWM_W + 1) ? ENV_W + 3 : PWM_W + 1;
  localparam logic [ENV_W-1:0] ENV_MAX = '1;
  localparam logic [PWM_W-1:0] MIX_MAX = '1;

  typedef enum logic [1:0] {
    V_IDLE    = 2'd0,
    V_SUSTAIN = 2'd1,
    V_DECAY   = 2'd2
  } vstate_e;

  function automatic logic [PWM_W-1:0] sat_mix(input logic [SUM_W-1:0] s);
    if (s > SUM_W'(MIX_MAX)) return MIX_MAX;
    else                     return s[PWM_W-1:0];
  endfunction

`ifdef APU_NOISE_EN
  function automatic logic [12:0] lfsr_next(input logic [12:0] l);
    return {l[11:0], ~(l[12] ^ l[8] ^ l[2] ^ l[0])};
  endfunction
`endif

  // One-entry trigger holding register
  logic                pend_vld_q,    pend_vld_d;
  logic [VOICE_W-1:0]  pend_voice_q,  pend_voice_d;
  logic [PERIOD_W-1:0] pend_period_q, pend_period_d;
  logic [LEN_W-1:0]    pend_len_q,    pend_len_d;

  // Per-voice state
  vstate_e             state_q [NV];
  vstate_e             state_d [NV];
  logic [ENV_W-1:0]    env_q   [NV];
  logic [ENV_W-1:0]    env_d   [NV];
  logic [LEN_W-1:0]    len_q   [NV];
  logic [LEN_W-1:0]    len_d   [NV];
  logic [PERIOD_W-1:0] per_q   [NV];
  logic [PERIOD_W-1:0] per_d   [NV];
  logic [PERIOD_W-1:0] cnt_q   [NV];
  logic [PERIOD_W-1:0] cnt_d   [NV];
  logic                sq_q    [NV];
  logic                sq_d    [NV];

  logic                trig_err_q, trig_err_d;
  logic [PWM_W-1:0]    mix_q,      mix_d;
  logic [PWM_W-1:0]    pwm_q,      pwm_d;
  logic                audio_q,    audio_d;
`ifdef APU_NOISE_EN
  logic [12:0]         lfsr_q,     lfsr_d;
  logic                noise_wrap;
`endif

  logic                accept;
  logic [NV-1:0]       hit;
  logic [SUM_W-1:0]    sum;
  logic                amp_src;

  assign trig.trig_ready = ~pend_vld_q;
  assign accept          = trig.trig_valid & ~pend_vld_q;

  always_comb begin
    // ---- capture stage: accepted request parks for one cycle ----
    pend_vld_d    = accept;
    pend_voice_d  = accept ? trig.trig_voice  : pend_voice_q;
    pend_period_d = accept ? trig.trig_period : pend_period_q;
    pend_len_d    = accept ? trig.trig_len    : pend_len_q;

    for (int i = 0; i < NV; i++) begin
      hit[i] = pend_vld_q && (pend_voice_q == VOICE_W'(i));
    end
    // A parked request that matches no voice is dropped and flagged.
    trig_err_d = trig_err_q | (pend_vld_q & ~(|hit));

    // ---- voice stage ----
    state_d = state_q;
    env_d   = env_q;
    len_d   = len_q;
    per_d   = per_q;
    cnt_d   = cnt_q;
    sq_d    = sq_q;
`ifdef APU_NOISE_EN
    noise_wrap = 1'b0;
`endif

    for (int i = 0; i < NV; i++) begin
      if (hit[i]) begin
        // Trigger restarts from any state and overrides a same-cycle frame_tick.
        state_d[i] = (pend_len_q != '0) ? V_SUSTAIN : V_DECAY;
        env_d[i]   = ENV_MAX;
        len_d[i]   = pend_len_q;
        per_d[i]   = pend_period_q;
        cnt_d[i]   = '0;
        sq_d[i]    = (pend_period_q != '0);
      end else if (state_q[i] != V_IDLE) begin
        if (line_tick) begin
          if (per_q[i] == '0) begin
            sq_d[i] = 1'b0;
          end else if (({1'b0, cnt_q[i]} + 1'b1) >= {1'b0, per_q[i]}) begin
            cnt_d[i] = '0;
            sq_d[i]  = ~sq_q[i];
`ifdef APU_NOISE_EN
            if (i == NV - 1) noise_wrap = 1'b1;
`endif
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        if (frame_tick) begin
          if (state_q[i] == V_SUSTAIN) begin
            len_d[i] = len_q[i] - 1'b1;
            if (len_q[i] == LEN_W'(1)) state_d[i] = V_DECAY;
          end else begin
            env_d[i] = env_q[i] - 1'b1;
            if (env_q[i] == ENV_W'(1)) begin
              // Envelope exhausted: idle holds the square low.
              state_d[i] = V_IDLE;
              sq_d[i]    = 1'b0;
              cnt_d[i]   = '0;
            end
          end
        end
      end
    end

`ifdef APU_NOISE_EN
    lfsr_d = noise_wrap ? lfsr_next(lfsr_q) : lfsr_q;
`endif

    // ---- mix stage: from registered voice state ----
    sum = '0;
    for (int i = 0; i < NV; i++) begin
      amp_src = sq_q[i];
`ifdef APU_NOISE_EN
      if (i == NV - 1) amp_src = lfsr_q[0];
`endif
      if (amp_src) sum = sum + SUM_W'(env_q[i]);
    end
    mix_d = sat_mix(sum);

    // ---- PWM stage ----
    pwm_d   = pwm_q + 1'b1;
    audio_d = (mix_q > pwm_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_vld_q    <= 1'b0;
      pend_voice_q  <= '0;
      pend_period_q <= '0;
      pend_len_q    <= '0;
      for (int i = 0; i < NV; i++) begin
        state_q[i] <= V_IDLE;
        env_q[i]   <= '0;
        len_q[i]   <= '0;
        per_q[i]   <= '0;
        cnt_q[i]   <= '0;
        sq_q[i]    <= 1'b0;
      end
      trig_err_q <= 1'b0;
      mix_q      <= '0;
      pwm_q      <= '0;
      audio_q    <= 1'b0;
`ifdef APU_NOISE_EN
      lfsr_q     <= 13'h0001;
`endif
    end else begin
      pend_vld_q    <= pend_vld_d;
      pend_voice_q  <= pend_voice_d;
      pend_period_q <= pend_period_d;
      pend_len_q    <= pend_len_d;
      state_q       <= state_d;
      env_q         <= env_d;
      len_q         <= len_d;
      per_q         <= per_d;
      cnt_q         <= cnt_d;
      sq_q          <= sq_d;
      trig_err_q    <= trig_err_d;
      mix_q         <= mix_d;
      pwm_q         <= pwm_d;
      audio_q       <= audio_d;
`ifdef APU_NOISE_EN
      lfsr_q        <= lfsr_d;
`endif
    end
  end

  always_comb begin
    voice_active = '0;
    for (int i = 0; i < NV; i++) begin
      voice_active[i] = (state_q[i] != V_IDLE);
    end
  end

  assign trig_err  = trig_err_q;
  assign audio_out = audio_q;

endmodule

// File: tb/tb_apu_voice_sequencer.sv
// Bench for apu_voice_sequencer: a cycle-level model of the voice rules
// tracks every output and is compared on each falling edge, plus literal
// expectations at key points of each directed scenario.
module tb_apu_voice_sequencer;
  localparam int NUM_VOICES = 3;
`ifdef APU_NOISE_EN
  localparam int NVM = NUM_VOICES + 1;
`else
  localparam int NVM = NUM_VOICES;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic line_tick = 1'b0;
  logic frame_tick = 1'b0;
  logic [NUM_VOICES:0] voice_active;
  logic trig_err;
  logic audio_out;

  apu_voice_sequencer_if #(.NUM_VOICES(NUM_VOICES), .PERIOD_W(10), .LEN_W(6)) tif();

  apu_voice_sequencer #(
    .NUM_VOICES(NUM_VOICES), .PERIOD_W(10), .ENV_W(5), .LEN_W(6), .PWM_W(7)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .line_tick    (line_tick),
    .frame_tick   (frame_tick),
    .trig         (tif),
    .voice_active (voice_active),
    .trig_err     (trig_err),
    .audio_out    (audio_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit frame_auto = 1'b1;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int  m_state [NVM];   // 0 idle, 1 sustain, 2 decay
  int  m_env   [NVM];
  int  m_len   [NVM];
  int  m_per   [NVM];
  int  m_cnt   [NVM];
  bit  m_sq    [NVM];
  bit  m_pend, m_err, m_audio, m_acc, m_src;
  int  m_pv, m_pp, m_pl, m_mix, m_pwm, m_sum;
`ifdef APU_NOISE_EN
  bit [12:0] m_lfsr;
`endif

  function automatic logic [NUM_VOICES:0] m_active();
    logic [NUM_VOICES:0] r;
    r = '0;
    for (int v = 0; v < NVM; v++) r[v] = (m_state[v] != 0);
    return r;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int v = 0; v < NVM; v++) begin
        m_state[v] = 0; m_env[v] = 0; m_len[v] = 0;
        m_per[v] = 0; m_cnt[v] = 0; m_sq[v] = 1'b0;
      end
      m_pend = 0; m_err = 0; m_mix = 0; m_pwm = 0; m_audio = 0;
`ifdef APU_NOISE_EN
      m_lfsr = 13'h0001;
`endif
    end else begin
      // Output chain uses the voice picture before this edge.
      m_sum = 0;
      for (int v = 0; v < NVM; v++) begin
        m_src = m_sq[v];
`ifdef APU_NOISE_EN
        if (v == NUM_VOICES) m_src = m_lfsr[0];
`endif
        if (m_src) m_sum += m_env[v];
      end
      m_audio = (m_mix > m_pwm);
      m_mix   = (m_sum > 127) ? 127 : m_sum;
      m_pwm   = (m_pwm + 1) % 128;

      for (int v = 0; v < NVM; v++) begin
        if (m_pend && m_pv == v) begin
          m_state[v] = (m_pl != 0) ? 1 : 2;
          m_env[v] = 31; m_len[v] = m_pl; m_per[v] = m_pp;
          m_cnt[v] = 0; m_sq[v] = (m_pp != 0);
        end else if (m_state[v] != 0) begin
          if (line_tick) begin
            if (m_per[v] == 0) m_sq[v] = 1'b0;
            else if (m_cnt[v] >= m_per[v] - 1) begin
              m_cnt[v] = 0;
              m_sq[v] = !m_sq[v];
`ifdef APU_NOISE_EN
              if (v == NUM_VOICES)
                m_lfsr = {m_lfsr[11:0], ~(m_lfsr[12] ^ m_lfsr[8] ^ m_lfsr[2] ^ m_lfsr[0])};
`endif
            end else m_cnt[v]++;
          end
          if (frame_tick) begin
            if (m_state[v] == 1) begin
              m_len[v]--;
              if (m_len[v] == 0) m_state[v] = 2;
            end else begin
              m_env[v]--;
              if (m_env[v] == 0) begin
                m_state[v] = 0; m_sq[v] = 1'b0; m_cnt[v] = 0;
              end
            end
          end
        end
      end
      if (m_pend && m_pv >= NVM) m_err = 1;

      m_acc = tif.trig_valid && !m_pend;
      m_pend = m_acc;
      if (m_acc) begin
        m_pv = int'(tif.trig_voice);
        m_pp = int'(tif.trig_period);
        m_pl = int'(tif.trig_len);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("trig_ready", int'(tif.trig_ready), int'(!m_pend));
      chk("voice_active", int'(voice_active), int'(m_active()));
      chk("trig_err", int'(trig_err), int'(m_err));
      chk("audio_out", int'(audio_out), int'(m_audio));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
      line_tick  = (cyc % 4 == 0);
      frame_tick = frame_auto && (cyc % 64 == 0);
    end
  endtask

  task automatic frame_pulse(input int n);
    repeat (n) begin
      frame_tick = 1'b1;
      step(1);
    end
  endtask

  // Returns in the cycle after acceptance (pending cycle).
  task automatic fire(input int v, input int p, input int l, input bit tick_apply);
    bit done;
    done = 1'b0;
    tif.trig_voice  = 2'(v);
    tif.trig_period = 10'(p);
    tif.trig_len    = 6'(l);
    tif.trig_valid  = 1'b1;
    for (int t = 0; t < 8 && !done; t++) begin
      done = tif.trig_ready;
      step(1);
    end
    chk("fire_accept", int'(done), 1);
    tif.trig_valid = 1'b0;
    if (tick_apply) frame_tick = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int frames;
    int guard;
    int highs;
    tif.trig_valid = 1'b0;
    tif.trig_voice = '0;
    tif.trig_period = '0;
    tif.trig_len = '0;

    // 1: reset, then idle
    step(1);
    chk_en = 1'b1;
    step(3);
    reset = 1'b0;
    chk("rst_active", int'(voice_active), 0);
    chk("rst_ready", int'(tif.trig_ready), 1);
    chk("rst_err", int'(trig_err), 0);
    chk("rst_audio", int'(audio_out), 0);
    step(1000);
    chk("idle_audio", int'(audio_out), 0);

    // 2: voice0 period 4 len 2, free-running ticks
    fire(0, 4, 2, 1'b0);
    chk("t2_ready_low", int'(tif.trig_ready), 0);
    chk("t2_not_yet", int'(voice_active[0]), 0);
    step(1);
    chk("t2_ready_back", int'(tif.trig_ready), 1);
    chk("t2_active", int'(voice_active[0]), 1);
    frames = 0;
    guard = 0;
    while (voice_active[0] && guard < 4000) begin
      if (frame_tick) frames++;
      step(1);
      guard++;
    end
    chk("t2_idle", int'(voice_active[0]), 0);
    chk("t2_frames_to_idle", frames, 33);
    step(3);
    chk("t2_silent", int'(audio_out), 0);

    // 3: voice1 len 0 with frame_tick in the apply cycle
    frame_auto = 1'b0;
    fire(1, 3, 0, 1'b1);
    step(1);
    frame_pulse(30);
    step(2);
    chk("t3_alive_after30", int'(voice_active[1]), 1);
    frame_pulse(1);
    chk("t3_idle_after31", int'(voice_active[1]), 0);

    // 4: retrigger voice0 while decaying at env 10
    fire(0, 4, 2, 1'b0);
    step(1);
    frame_pulse(2 + 21);
    step(20);
    fire(0, 4, 2, 1'b0);
    step(20);
    frame_pulse(32);
    step(2);
    chk("t4_alive_after32", int'(voice_active[0]), 1);
    frame_pulse(1);
    chk("t4_idle_after33", int'(voice_active[0]), 0);

    // 5: three voices at full envelope, square high
    fire(0, 1023, 63, 1'b0);
    fire(1, 1023, 63, 1'b0);
    fire(2, 1023, 63, 1'b0);
    step(4);
    highs = 0;
    for (int k = 0; k < 128; k++) begin
      if (audio_out) highs++;
      step(1);
    end
    chk("t5_duty", highs, 93);

    // reset mid-note
    reset = 1'b1;
    step(1);
    chk("midrst_active", int'(voice_active), 0);
    chk("midrst_audio", int'(audio_out), 0);
    step(1);
    reset = 1'b0;
    step(2);
    chk("midrst_err", int'(trig_err), 0);

    // 6: voice index NUM_VOICES
    frame_auto = 1'b1;
    fire(3, 5, 4, 1'b0);
    step(1);
`ifdef APU_NOISE_EN
    chk("t6_noise_active", int'(voice_active[3]), 1);
    chk("t6_no_err", int'(trig_err), 0);
`else
    chk("t6_err", int'(trig_err), 1);
    chk("t6_no_change", int'(voice_active), 0);
`endif
    step(200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
